// File: rtl/wide_pattern_gen.sv
//============================================================================
// Module   : wide_pattern_gen
// Purpose  : Emits a fixed sequence of 32-bit test words NUM_LOOPS times per
//            start request. Supports hold, abort and a one-cycle done pulse.
// Options  : WIDE_PATTERN_GEN_WALK1_EN - appends 32 walking-one words
//            (idx 11..42) to every loop.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module wide_pattern_gen #(
    parameter int NUM_LOOPS = 1,
    parameter int WIDTH     = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] d_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [5:0]       word_idx
);

    // Only a 32-bit datapath and a loop count that fits the 8-bit counter exist.
    generate
        if (WIDTH != 32) begin : g_bad_width
            $error("wide_pattern_gen: WIDTH must be 32");
        end
        if ((NUM_LOOPS < 1) || (NUM_LOOPS > 255)) begin : g_bad_loops
            $error("wide_pattern_gen: NUM_LOOPS must be within 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef WIDE_PATTERN_GEN_WALK1_EN
    localparam logic [5:0] c_last_idx = 6'd42;
`else
    localparam logic [5:0] c_last_idx = 6'd10;
`endif
    localparam logic [7:0] c_last_loop = 8'(NUM_LOOPS - 1);

    // Word lookup; indices beyond 10 only exist when walking-ones are enabled.
    function automatic logic [31:0] f_word(input logic [5:0] idx);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (idx)
            6'd0:    w = 32'h0000_0000;
            6'd1:    w = 32'hFFFF_FFFF;
            6'd2:    w = 32'hFFFF_0000;
            6'd3:    w = 32'h0000_FFFF;
            6'd4:    w = 32'h5555_5555;
            6'd5:    w = 32'hAAAA_AAAA;
            6'd6:    w = 32'h1111_1111;
            6'd7:    w = 32'h2222_2222;
            6'd8:    w = 32'h4444_4444;
            6'd9:    w = 32'h8888_8888;
            6'd10:   w = 32'h0000_0000;
            default: begin
`ifdef WIDE_PATTERN_GEN_WALK1_EN
                w = 32'd1 << (idx - 6'd11);
`else
                w = 32'h0000_0000;
`endif
            end
        endcase
        return w;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_word_idx;
    logic [5:0]  w_idx_nxt;
    logic [7:0]  r_loop_cnt;
    logic [7:0]  w_loop_nxt;
    logic [31:0] r_d_out;
    logic [31:0] w_dout_nxt;

    // Next-state logic; the data word is looked up from the next index so that
    // d_out and word_idx change in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_word_idx;
        w_loop_nxt  = r_loop_cnt;
        w_dout_nxt  = r_d_out;
        case (r_state)
            IDLE: begin
                w_idx_nxt  = 6'd0;
                w_loop_nxt = 8'd0;
                w_dout_nxt = 32'h0000_0000;
                if (start) begin
                    w_state_nxt = RUN;
                    w_dout_nxt  = f_word(6'd0);
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 6'd0;
                    w_loop_nxt  = 8'd0;
                    w_dout_nxt  = 32'h0000_0000;
                end else if (hold) begin
                    w_state_nxt = RUN;
                end else if (r_word_idx == c_last_idx) begin
                    w_idx_nxt = 6'd0;
                    if (r_loop_cnt == c_last_loop) begin
                        w_state_nxt = DONE;
                        w_loop_nxt  = 8'd0;
                        w_dout_nxt  = 32'h0000_0000;
                    end else begin
                        w_loop_nxt = r_loop_cnt + 8'd1;
                        w_dout_nxt = f_word(6'd0);
                    end
                end else begin
                    w_idx_nxt  = r_word_idx + 6'd1;
                    w_dout_nxt = f_word(r_word_idx + 6'd1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 6'd0;
                w_loop_nxt  = 8'd0;
                w_dout_nxt  = 32'h0000_0000;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 6'd0;
                w_loop_nxt  = 8'd0;
                w_dout_nxt  = 32'h0000_0000;
            end
        endcase
    end

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_word_idx <= 6'd0;
            r_loop_cnt <= 8'd0;
            r_d_out    <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_idx_nxt;
            r_loop_cnt <= w_loop_nxt;
            r_d_out    <= w_dout_nxt;
        end
    end

    assign d_out    = r_d_out;
    assign word_idx = r_word_idx;
    assign valid    = (r_state == RUN);
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_wide_pattern_gen.sv
//============================================================================
// Module   : tb_wide_pattern_gen
// Purpose  : Directed self-checking bench for wide_pattern_gen (single-loop
//            and three-loop instances). Follows WIDE_PATTERN_GEN_WALK1_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_wide_pattern_gen;

`ifdef WIDE_PATTERN_GEN_WALK1_EN
    localparam int c_len = 43;
`else
    localparam int c_len = 11;
`endif
    localparam int c_nvec = 19;

    logic        clock;
    logic        rst;
    logic        start;
    logic        start3;
    logic        hold;
    logic        abort;
    logic [31:0] d_out;
    logic        valid;
    logic        busy;
    logic        done;
    logic [5:0]  word_idx;
    logic [31:0] d_out3;
    logic        valid3;
    logic        busy3;
    logic        done3;
    logic [5:0]  word_idx3;

    int n_cmp;
    int n_fail;

    wide_pattern_gen #(.NUM_LOOPS(1), .WIDTH(32)) dut (
        .clock(clock), .rst(rst), .start(start), .hold(hold), .abort(abort),
        .d_out(d_out), .valid(valid), .busy(busy), .done(done), .word_idx(word_idx)
    );

    wide_pattern_gen #(.NUM_LOOPS(3), .WIDTH(32)) dut3 (
        .clock(clock), .rst(rst), .start(start3), .hold(hold), .abort(abort),
        .d_out(d_out3), .valid(valid3), .busy(busy3), .done(done3), .word_idx(word_idx3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        hold;
        logic        abort;
        logic        valid;
        logic        busy;
        logic        done;
        logic [5:0]  idx;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [c_nvec];

    function automatic logic [31:0] exp_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:  w = 32'h0000_0000;
            1:  w = 32'hFFFF_FFFF;
            2:  w = 32'hFFFF_0000;
            3:  w = 32'h0000_FFFF;
            4:  w = 32'h5555_5555;
            5:  w = 32'hAAAA_AAAA;
            6:  w = 32'h1111_1111;
            7:  w = 32'h2222_2222;
            8:  w = 32'h4444_4444;
            9:  w = 32'h8888_8888;
            10: w = 32'h0000_0000;
            default: begin
                w = 32'd1;
                w = w << (idx - 11);
            end
        endcase
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_vec(input int i, input logic s, input logic h, input logic a,
                           input logic v, input logic b, input logic d,
                           input logic [5:0] idx, input logic [31:0] dout);
        vecs[i].start = s;  vecs[i].hold = h;  vecs[i].abort = a;
        vecs[i].valid = v;  vecs[i].busy = b;  vecs[i].done = d;
        vecs[i].idx   = idx; vecs[i].dout = dout;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 32'(valid), 32'd0);
        check({tag, " busy"},  32'(busy),  32'd0);
        check({tag, " done"},  32'(done),  32'd0);
        check({tag, " idx"},   32'(word_idx), 32'd0);
        check({tag, " dout"},  d_out, 32'h0);
    endtask

    initial begin
        int nvalid;
        int wraps;
        int exp_i;
        int ndone;

        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        hold   = 1'b0;
        abort  = 1'b0;

        //        s     h     a     v     b     d     idx    dout
        set_vec(0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0000_0000);
        set_vec(1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 32'hFFFF_FFFF);
        set_vec(2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2, 32'hFFFF_0000);
        set_vec(3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd3, 32'h0000_FFFF);
        set_vec(4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd4, 32'h5555_5555);
        set_vec(5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd4, 32'h5555_5555);
        set_vec(6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd4, 32'h5555_5555);
        set_vec(7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd4, 32'h5555_5555);
        set_vec(8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5, 32'hAAAA_AAAA);
        set_vec(9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd6, 32'h1111_1111);
        set_vec(10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd7, 32'h2222_2222);
        set_vec(11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0000_0000);
        set_vec(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0000_0000);
        set_vec(13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0000_0000);
        set_vec(14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 32'hFFFF_FFFF);
        set_vec(15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0000_0000);
        set_vec(16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0000_0000);
        set_vec(17, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0000_0000);
        set_vec(18, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0000_0000);

        // Reset for two cycles, then a full single-loop sequence
        tick();
        check_idle("reset1");
        tick();
        check_idle("reset2");
        rst   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < c_len; i++) begin
            check($sformatf("seq%0d valid", i), 32'(valid), 32'd1);
            check($sformatf("seq%0d busy", i),  32'(busy),  32'd1);
            check($sformatf("seq%0d done", i),  32'(done),  32'd0);
            check($sformatf("seq%0d idx", i),   32'(word_idx), 32'(i));
            check($sformatf("seq%0d dout", i),  d_out, exp_word(i));
            if (i == c_len - 1) start = 1'b1;
            tick();
        end
        check("done pulse done",  32'(done),  32'd1);
        check("done pulse valid", 32'(valid), 32'd0);
        check("done pulse busy",  32'(busy),  32'd0);
        check("done pulse dout",  d_out, 32'h0);
        tick();
        check_idle("after done");
        start = 1'b0;
        tick();
        check_idle("idle");

        // Table-driven hold / abort / ignored-start vectors
        for (int i = 0; i < c_nvec; i++) begin
            start = vecs[i].start;
            hold  = vecs[i].hold;
            abort = vecs[i].abort;
            tick();
            check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d busy", i),  32'(busy),  32'(vecs[i].busy));
            check($sformatf("vec%0d done", i),  32'(done),  32'(vecs[i].done));
            check($sformatf("vec%0d idx", i),   32'(word_idx), 32'(vecs[i].idx));
            check($sformatf("vec%0d dout", i),  d_out, vecs[i].dout);
        end
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;

        // Reset mid-sequence at idx 5 with start held high
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("pre-reset idx", 32'(word_idx), 32'd5);
        rst   = 1'b0;
        start = 1'b1;
        tick();
        check_idle("midreset1");
        tick();
        check_idle("midreset2");
        rst = 1'b1;
        tick();
        check("restart valid", 32'(valid), 32'd1);
        check("restart idx",   32'(word_idx), 32'd0);
        check("restart dout",  d_out, 32'h0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("post-abort");

        // Three loops back to back on the second instance
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        nvalid = 0;
        wraps  = 0;
        exp_i  = 0;
        for (int c = 0; c < 300; c++) begin
            if (valid3 !== 1'b1) break;
            if (nvalid > 0 && word_idx3 == 6'd0) wraps++;
            check($sformatf("l3 cyc%0d idx", c),  32'(word_idx3), 32'(exp_i));
            check($sformatf("l3 cyc%0d dout", c), d_out3, exp_word(exp_i));
            check($sformatf("l3 cyc%0d done", c), 32'(done3), 32'd0);
            nvalid++;
            exp_i = (exp_i == c_len - 1) ? 0 : exp_i + 1;
            tick();
        end
        check("l3 valid count", 32'(nvalid), 32'(3 * c_len));
        check("l3 wraps",       32'(wraps),  32'd2);
        check("l3 done",        32'(done3),  32'd1);
        check("l3 busy",        32'(busy3),  32'd0);
        check("l3 dout",        d_out3,      32'h0);
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done3 === 1'b1) ndone++;
        end
        check("l3 extra done", 32'(ndone), 32'd0);
        check("l3 idle valid", 32'(valid3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
